// File: rtl/hp_unpack.sv
// Half-precision operand unpacker: splits a classified operand into sign,
// unbiased exponent and explicit-hidden-bit significand, normalising subnormals.
module hp_unpack #(
  parameter int unsigned NEXP = 5,
  parameter int unsigned NSIG = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NEXP+NSIG:0]   f,
  input  logic                 snan,
  input  logic                 qnan,
  input  logic                 infinity,
  input  logic                 zero,
  input  logic                 subnormal,
  input  logic                 normal,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [NEXP:0]        out_exp,
  output logic [NSIG:0]        out_sig,
  output logic [5:0]           out_class,
  output logic                 out_err
);

  localparam int unsigned FW   = NEXP + NSIG + 1;
  localparam int unsigned EW   = NEXP + 1;
  localparam int unsigned SW   = NSIG + 1;
  localparam int unsigned BIAS = (1 << (NEXP - 1)) - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          valid_nxt, sign_nxt, err_nxt;
  logic [EW-1:0] exp_nxt;
  logic [SW-1:0] sig_nxt, sig_shl;
  logic [5:0]    cls, cls_nxt;
  logic          cls_onehot;

  assign cls        = {snan, qnan, infinity, zero, subnormal, normal};
  assign cls_onehot = $onehot(cls);
  assign sig_shl    = {out_sig[SW-2:0], 1'b0};
  assign in_ready   = (state == IDLE) & ~rst;

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    sign_nxt  = out_sign;
    exp_nxt   = out_exp;
    sig_nxt   = out_sig;
    cls_nxt   = out_class;
    err_nxt   = out_err;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = HOLD;
          sign_nxt  = f[FW-1];
          cls_nxt   = cls;
          err_nxt   = ~cls_onehot;
          if (!cls_onehot) begin
            exp_nxt = '0;
            sig_nxt = '0;
          end else if (normal) begin
            exp_nxt = EW'(f[FW-2:NSIG]) - EW'(BIAS);
            sig_nxt = {1'b1, f[NSIG-1:0]};
          end else if (zero) begin
            exp_nxt = '0;
            sig_nxt = '0;
          end else if (infinity) begin
            exp_nxt = EW'(1 << (NEXP - 1));
            sig_nxt = {1'b1, {NSIG{1'b0}}};
          end else if (snan || qnan) begin
            exp_nxt = EW'(1 << (NEXP - 1));
            sig_nxt = {1'b1, f[NSIG-1:0]};
          end else begin
            state_nxt = NORM;
            exp_nxt   = EW'(1) - EW'(BIAS);
            sig_nxt   = {1'b0, f[NSIG-1:0]};
          end
        end
      end
      NORM: begin
        sig_nxt = sig_shl;
        exp_nxt = out_exp - EW'(1);
        // A zero fraction flagged subnormal would never normalise; bail out.
        if (sig_shl[SW-1] || (sig_shl == '0)) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    valid_nxt = (state_nxt == HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_sig   <= '0;
      out_class <= '0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      out_sign  <= sign_nxt;
      out_exp   <= exp_nxt;
      out_sig   <= sig_nxt;
      out_class <= cls_nxt;
      out_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_hp_unpack.sv
// Self-checking bench for hp_unpack: model results queued at drive time,
// popped and compared when the unpacker presents them.
module tb_hp_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] f;
  logic        snan, qnan, infinity, zero, subnormal, normal;
  logic        out_valid, out_ready, out_sign, out_err;
  logic [5:0]  out_exp, out_class;
  logic [10:0] out_sig;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        sign;
    logic [5:0]  exp;
    logic [10:0] sig;
    logic [5:0]  cls;
    logic        err;
    logic [4:0]  lat;
  } exp_t;

  exp_t sbq[$];

  hp_unpack #(.NEXP(5), .NSIG(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .f(f),
    .snan(snan), .qnan(qnan), .infinity(infinity), .zero(zero),
    .subnormal(subnormal), .normal(normal),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig),
    .out_class(out_class), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s got=%0h want=%0h", tag, got, want);
    else n_pass++;
  endtask

  // Reference model: value-level decode, subnormals normalised by bit position
  function automatic exp_t model(input logic [15:0] fv, input logic [5:0] cv);
    exp_t e;
    int   ev, frac, p, k;
    ev   = int'(fv[14:10]);
    frac = int'(fv[9:0]);
    e.sign = fv[15];
    e.cls  = cv;
    e.err  = 1'b0;
    e.lat  = 5'd1;
    if ($countones(cv) != 1) begin
      e.err = 1'b1; e.exp = '0; e.sig = '0;
    end else if (cv[0]) begin
      e.exp = 6'(ev - 15); e.sig = {1'b1, fv[9:0]};
    end else if (cv[2]) begin
      e.exp = '0; e.sig = '0;
    end else if (cv[3]) begin
      e.exp = 6'd16; e.sig = 11'h400;
    end else if (cv[5] || cv[4]) begin
      e.exp = 6'd16; e.sig = {1'b1, fv[9:0]};
    end else begin
      p = 0;
      for (int b = 0; b < 10; b++) if (frac[b]) p = b;
      k = 10 - p;
      e.exp = 6'(-14 - k);
      e.sig = 11'(frac << k);
      e.lat = 5'(k + 1);
    end
    return e;
  endfunction

  task automatic drive(input logic [15:0] fv, input logic [5:0] cv);
    f = fv;
    {snan, qnan, infinity, zero, subnormal, normal} = cv;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   n;
    logic [5:0] cls_hold;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(e.lat));
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("sign", 32'(out_sign), 32'(e.sign));
    chk("exp", 32'(out_exp), 32'(e.exp));
    chk("sig", 32'(out_sig), 32'(e.sig));
    chk("class", 32'(out_class), 32'(e.cls));
    chk("err", 32'(out_err), 32'(e.err));
    cls_hold = {snan, qnan, infinity, zero, subnormal, normal};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      f = ~f;
      {snan, qnan, infinity, zero, subnormal, normal} = ~cls_hold;
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_stable", {14'd0, out_exp, out_sig, 1'b0},
          {14'd0, e.exp, e.sig, 1'b0});
      chk("hold_class", 32'(out_class), 32'(e.cls));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("ready_again", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input logic [15:0] fv, input logic [5:0] cv, input int hold);
    sbq.push_back(model(fv, cv));
    drive(fv, cv);
    collect(hold);
  endtask

  initial begin
    int          rose;
    logic [15:0] rf;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; f = '0;
    {snan, qnan, infinity, zero, subnormal, normal} = 6'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_regs", {19'd0, out_exp, out_sig}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(16'h3C00, 6'b000001, 0);
    run(16'h0001, 6'b000010, 0);
    run(16'h8200, 6'b000010, 0);
    run(16'h7C00, 6'b001000, 0);
    run(16'h7E00, 6'b010000, 0);
    run(16'h7C01, 6'b100000, 0);
    run(16'h0000, 6'b000100, 0);
    run(16'hABCD, 6'b000011, 0);
    run(16'h3555, 6'b000001, 5);

    for (int i = 0; i < 4; i++) begin
      rf = {1'(i), 5'($urandom_range(1, 30)), 10'($urandom)};
      run(rf, 6'b000001, 0);
    end
    for (int i = 0; i < 3; i++) begin
      rf = {1'($urandom), 5'd0, 10'($urandom_range(1, 1023))};
      run(rf, 6'b000010, 0);
    end

    // Reset in the middle of a deep normalisation
    drive(16'h0001, 6'b000010);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_regs", {19'd0, out_exp, out_sig}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    rose = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1;
    end
    chk("aborted_never_valid", 32'(rose), 32'd0);
    run(16'h3C00, 6'b000001, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hp_unpack.md
Name: hp_unpack

Overview:
- Downstream consumer of the half-precision classifier (hp_class).
- Accepts an encoded operand plus its six class flags over a valid/ready handshake.
- Emits the unpacked sign, unbiased signed exponent and explicit-hidden-bit significand for arithmetic stages.
- Subnormals are normalised iteratively, one left shift per cycle, so every non-zero finite output has significand MSB = 1.

Parameters:
- NEXP, 5, exponent field width; bias = 2^(NEXP-1)-1.
- NSIG, 10, stored fraction width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  block can accept; combinational = (state==IDLE) & ~rst.
- f  in  NEXP+NSIG+1  encoded operand.
- snan, qnan, infinity, zero, subnormal, normal  in  1 each  class flags from hp_class.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  f[MSB].
- out_exp  out  NEXP+1  unbiased exponent, two's complement.
- out_sig  out  NSIG+1  significand with explicit hidden bit.
- out_class  out  6  {snan,qnan,infinity,zero,subnormal,normal} as captured.
- out_err  out  1  captured class vector was not one-hot.

Behaviour:
- States: IDLE, NORM, HOLD. Reset (async) forces IDLE and clears all output registers to 0. out_valid=0 during and after reset.
- Accept: in_valid & in_ready at a rising edge. in_valid is ignored in NORM and HOLD.
- On accept, the next state and registered outputs are:
  - Class not one-hot: HOLD; out_err=1, exp=0, sig=0, sign=f[MSB].
  - normal: HOLD; exp = E - bias, sig = {1, frac}.
  - zero: HOLD; exp=0, sig=0.
  - infinity: HOLD; exp = 2^(NEXP-1), sig = {1, 0}.
  - snan or qnan: HOLD; exp = 2^(NEXP-1), sig = {1, frac}.
  - subnormal: NORM; exp = 1 - bias, sig = {0, frac}.
- NORM, each cycle: sig <= sig<<1 and exp <= exp-1. If the shifted sig has MSB=1, go to HOLD.
  - Shift count k = (leading zeros of the NSIG-bit frac) + 1, range 1..NSIG.
- Latency: out_valid first high 1 cycle after the accept cycle for non-subnormals, k+1 cycles after for subnormals.
- HOLD: out_valid=1. All out_* stay stable while out_ready=0. On out_ready=1, go to IDLE and drop out_valid on that edge.
  - No bypass: at most one operand per 2 cycles.
- out_class and out_err are registered at accept and held through NORM/HOLD.
- Minimum half exponent -24 fits in NEXP+1 bits. Arithmetic is signed, with no saturation needed.
- Reset asserted mid-NORM or mid-HOLD aborts the operation immediately. The partial result is discarded and never presented.

Test Plan:
1. Normal: f=16'h3C00, class 000001 -> one cycle later out_valid=1, sign 0, exp 6'h00, sig 11'h400, class 000001, err 0.
2. Deep subnormal: f=16'h0001, class 000010 -> 10 NORM cycles; out_valid 11 cycles after accept; exp -24 (6'h28), sig 11'h400.
3. Shallow subnormal and sign: f=16'h8200 -> latency 2; sign 1, exp -15 (6'h31), sig 11'h400.
4. Specials, one at a time:
   - 16'h7C00 inf -> exp 6'h10, sig 11'h400.
   - 16'h7E00 qnan -> exp 6'h10, sig 11'h600.
   - 16'h7C01 snan -> exp 6'h10, sig 11'h401.
   - 16'h0000 zero -> exp 0, sig 0.
   - Class 000011 -> out_err=1.
5. Backpressure: f=16'h3555, out_ready held low 5 cycles -> outputs stable (exp 6'h3E, sig 11'h555), in_ready=0 throughout. out_ready high -> out_valid drops next edge, in_ready=1.
6. Reset mid-operation: f=16'h0001 accepted, rst pulsed after 4 NORM cycles -> out_valid=0 immediately and never rises for that operand; after release in_ready=1. Then f=16'h3C00 produces the case-1 result.
